// File: rtl/xclean_pkg.sv
// Shared types and defaults for the X-clean skid buffer feeding the X-checker.
package xclean_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/xclean_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered in_ready and an output that is
// forced to zero whenever it is not valid, so no X can reach the downstream checker.
module xclean_skid_buffer
    import xclean_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_count
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    // in_data is only ever copied on an accepted push, so an idle X bus never lands in a flop.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (pop) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Handshake outputs decode the state register only; out_ready never reaches in_ready.
    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
    end

    assign out_data   = main_q & {WIDTH{out_valid}};
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_xclean_skid_buffer.sv
// Bench for xclean_skid_buffer: queue-based reference model, per-cycle compare,
// inline X-check on the output bus, and directed vectors with literal expectations.
module tb_xclean_skid_buffer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] xfer_count;

    int errors = 0;
    int checks = 0;

    xclean_skid_buffer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of capacity two plus a wrapping transfer counter.
    logic [WIDTH-1:0] mq[$];
    logic [CNT_W-1:0] mcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt = '0;
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) begin
                void'(mq.pop_front());
                mcnt = mcnt + 1'b1;
            end
            if (do_push) mq.push_back(in_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare on the falling edge, plus the hold-while-stalled rule and X-check.
    logic             prev_v, prev_rdy;
    logic [WIDTH-1:0] prev_d;
    initial begin
        prev_v = 1'b0; prev_rdy = 1'b0; prev_d = '0;
    end

    always @(negedge clk) begin
        logic             exp_v;
        logic [WIDTH-1:0] exp_d;
        exp_v = (mq.size() > 0);
        exp_d = exp_v ? mq[0] : '0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
        chk("out_data", {24'd0, out_data}, {24'd0, exp_d});
        chk("xfer_count", {16'd0, xfer_count}, {16'd0, mcnt});
        chk("xcheck", {31'd0, $isunknown({out_valid, out_data, in_ready})}, 32'd0);
        if (rst_n && prev_v && !prev_rdy) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {24'd0, out_data}, {24'd0, prev_d});
        end
        prev_v   = out_valid && rst_n;
        prev_rdy = out_ready;
        prev_d   = out_data;
    end

    always @(negedge rst_n) prev_v = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 'x;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_count", {16'd0, xfer_count}, 32'd0);
        rst_n = 1'b1;

        // Idle with an X bus
        repeat (4) step();
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_out_data", {24'd0, out_data}, 32'd0);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Single push of A5 with downstream ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data  = 'x;
        chk("a5_valid", {31'd0, out_valid}, 32'd1);
        chk("a5_data", {24'd0, out_data}, 32'hA5);
        step();
        chk("a5_count", {16'd0, xfer_count}, 32'd1);
        chk("a5_drained", {31'd0, out_valid}, 32'd0);

        // Fill to TWO with 11,22; 33 must wait
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data = 8'h22;
        step();
        in_data = 8'h33;
        chk("two_in_ready", {31'd0, in_ready}, 32'd0);
        chk("two_head", {24'd0, out_data}, 32'h11);
        step();
        chk("two_still_full", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("drain1_data", {24'd0, out_data}, 32'h22);
        chk("drain1_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 'x;
        chk("drain2_data", {24'd0, out_data}, 32'h33);
        step();
        chk("drain_count", {16'd0, xfer_count}, 32'd3);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        // Back-to-back streaming 01..08
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            chk("stream_data", {24'd0, out_data}, i);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 'x;
        step();
        chk("stream_count", {16'd0, xfer_count}, 32'd11);

        // Asynchronous reset while full with FF/EE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        step();
        in_data = 8'hEE;
        step();
        in_valid = 1'b0;
        in_data  = 'x;
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, out_data}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_count", {16'd0, xfer_count}, 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_data", {24'd0, out_data}, 32'd0);

        // Counter wrap: 65535 pops, then one more
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        in_data  = 'x;
        chk("count_max", {16'd0, xfer_count}, 32'hFFFF);
        step();
        chk("count_wrap", {16'd0, xfer_count}, 32'h0000);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
